// File: rtl/syzygy_adc_frame_align.sv
// Frame-lane alignment controller: bitslips the ISERDES until the FR word matches FRAME_PATTERN.
// Optional macro SYZYGY_ADC_FRAME_MONITOR_EN keeps watching the frame word once aligned.
module syzygy_adc_frame_align #(
  parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MATCH_COUNT   = 64,
  parameter int unsigned MAX_SLIPS     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dco_locked,
  input  logic       realign,
  input  logic [7:0] frame_data,
  output logic       bitslip,
  output logic       aligned,
  output logic       align_error,
  output logic [3:0] slip_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSettle  = 3'd1,
    StCheck   = 3'd2,
    StSlip    = 3'd3,
    StAligned = 3'd4,
    StFail    = 3'd5
  } state_e;

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] MatchLast  = 8'(MATCH_COUNT - 1);
  localparam logic [3:0] MaxSlips   = 4'(MAX_SLIPS);

  state_e     state_q, state_d;
  logic       lock_meta_q, lock_s_q;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic [7:0] match_cnt_q, match_cnt_d;
  logic [3:0] slip_q, slip_d;
  logic       bitslip_q, aligned_q, align_error_q;
  logic       frame_match;

  assign frame_match = (frame_data == FRAME_PATTERN);

`ifdef SYZYGY_ADC_FRAME_MONITOR_EN
  logic [2:0] mis_cnt_q, mis_cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mis_cnt_q <= '0;
    else          mis_cnt_q <= mis_cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= dco_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    slip_d       = slip_q;
    settle_cnt_d = '0;
    match_cnt_d  = '0;
`ifdef SYZYGY_ADC_FRAME_MONITOR_EN
    mis_cnt_d    = '0;
`endif
    // Lock loss outranks realign; realign is meaningless while idle.
    if (!lock_s_q) begin
      state_d = StIdle;
      slip_d  = '0;
    end else if (realign && (state_q != StIdle)) begin
      state_d = StSettle;
      slip_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          slip_d  = '0;
          state_d = StSettle;
        end
        StSettle: begin
          if (settle_cnt_q >= SettleLast) state_d = StCheck;
          else settle_cnt_d = settle_cnt_q + 8'd1;
        end
        StCheck: begin
          if (frame_match) begin
            if (match_cnt_q >= MatchLast) state_d = StAligned;
            else match_cnt_d = match_cnt_q + 8'd1;
          end else if (slip_q < MaxSlips) begin
            state_d = StSlip;
          end else begin
            state_d = StFail;
          end
        end
        StSlip: begin
          if (slip_q < MaxSlips) slip_d = slip_q + 4'd1;
          state_d = StSettle;
        end
        StAligned: begin
`ifdef SYZYGY_ADC_FRAME_MONITOR_EN
          if (!frame_match) begin
            if (mis_cnt_q == 3'd3) begin
              state_d = StSettle;
              slip_d  = '0;
            end else begin
              mis_cnt_d = mis_cnt_q + 3'd1;
            end
          end
`endif
        end
        StFail: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      settle_cnt_q  <= '0;
      match_cnt_q   <= '0;
      slip_q        <= '0;
      bitslip_q     <= 1'b0;
      aligned_q     <= 1'b0;
      align_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      match_cnt_q   <= match_cnt_d;
      slip_q        <= slip_d;
      bitslip_q     <= (state_d == StSlip);
      aligned_q     <= (state_d == StAligned);
      align_error_q <= (state_d == StFail);
    end
  end

  assign bitslip     = bitslip_q;
  assign aligned     = aligned_q;
  assign align_error = align_error_q;
  assign slip_count  = slip_q;
  assign state       = state_q;

endmodule
